uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler and bit-rate sequencer for the shared 8-bit UART transmitter. Up to N_REQ byte sources present bytes on valid/ready handshakes. The block grants one source at a time and loads its byte into the transmitter with a one-cycle write pulse. It then generates the per-bit advance ticks and waits for the frame to complete before granting the next source.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CLKS_PER_BIT, 868, clock cycles per UART bit (≥2; 868 = 100 MHz / 115200)
- START_TIMEOUT, 4, cycles allowed for tx_busy to rise after a write pulse
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8·N_REQ  packed request bytes
- req_ready  out  N_REQ  one-hot accept; a byte transfers when valid&ready are both high
- tx_busy  in  1  transmitter frame in progress
- tx_write_en  out  1  one-cycle load pulse to the transmitter
- tx_data  out  8  byte to the transmitter, held stable from the write pulse until return to IDLE
- tx_tick  out  1  one-cycle bit-advance pulse to the transmitter
- grant_id  out  clog2(N_REQ)  index of the last granted requester
- active  out  1  high in any state other than IDLE
- err_no_start  out  1  sticky; set when tx_busy fails to rise within START_TIMEOUT

## Operation
- State machine states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Requires tx_busy=0 and at least one valid.
  - Winner: the first valid index searched from (last_grant+1) mod N_REQ upward, wrapping.
  - req_ready[winner]=1 combinationally in that cycle.
  - At the clock edge: tx_data ← winner's byte, grant_id ← winner, last_grant ← winner, state → ISSUE.
  - If tx_busy=1 in IDLE, no ready is asserted (foreign frame in progress).
- **ISSUE**
  - tx_write_en=1 for exactly this cycle.
  - Next state is WAIT_BUSY, and the timeout counter clears.
- **WAIT_BUSY**
  - tx_busy=1 → WAIT_DONE.
  - Otherwise the counter increments.
  - Once START_TIMEOUT cycles elapse without busy: err_no_start ← 1, state → IDLE.
- **WAIT_DONE**
  - tx_busy=0 → IDLE.
- **Bit-rate counter**, width clog2(CLKS_PER_BIT):
  - Held at 0 while tx_busy=0.
  - While tx_busy=1, it increments each cycle.
  - At count CLKS_PER_BIT-1: tx_tick=1 and the count wraps to 0.
  - The counter runs off tx_busy, not off the state, so ticks are also produced for frames the block did not issue.
- A frame consumes 10 ticks (start, 8 data, stop), so tx_busy stays high for 10·CLKS_PER_BIT cycles plus the transmitter's one-cycle entry latency.
- req_ready is never asserted outside IDLE. At most one bit is high.
- A requester that drops valid before being granted is simply skipped. No byte is lost or duplicated.

## Timing
- **Reset values:**
  - Outputs: req_ready=0, tx_write_en=0, tx_tick=0, tx_data=0, grant_id=0, active=0, err_no_start=0.
  - Internal: state IDLE, bit counter 0, last_grant=N_REQ-1 (requester 0 has first priority).
- **Grant pipeline:**
  - Cycle 0: accept in IDLE.
  - Cycle 1: tx_write_en.
  - Cycle 2: the transmitter is expected to raise tx_busy.
  - Next IDLE is the cycle after tx_busy is sampled low.
- **Throughput:** consecutive grants are at least 10·CLKS_PER_BIT+4 cycles apart.
- **First tick:** occurs CLKS_PER_BIT cycles after tx_busy first samples high.
- **Reset mid-frame:** every state and counter returns to its reset value on the next edge. No tick or write pulse is emitted in the cycle following reset.
- **Simultaneous tx_busy fall and new valid:** the block enters IDLE first and accepts in the following cycle.
- **err_no_start:** clears only on reset.

## Test plan
- Reset with req_valid=4'b0001 held, data 0x55, CLKS_PER_BIT=4 → req_ready=0001 in the cycle after reset deasserts, write pulse next cycle with tx_data=0x55, 10 tx_tick pulses spaced 4 cycles apart, active falls after busy drops.
- All four valid, bytes 0xA0..0xA3 → grants in order 0,1,2,3,0; grant_id sequence matches; each req_ready is a single-cycle pulse.
- Requester 2 only valid after last grant=3 → wrap search grants 2; drop requester 1's valid before its turn → it is skipped with no write pulse.
- Stub transmitter never raises tx_busy → err_no_start=1 exactly START_TIMEOUT cycles after WAIT_BUSY entry, return to IDLE, next request still granted.
- Assert reset during the 5th tick of a frame → all outputs at reset values next cycle, tick counter restarts at 0 on the next frame.
- tx_busy forced high externally in IDLE with valids pending → no req_ready, ticks every CLKS_PER_BIT cycles; grant occurs the cycle after busy falls.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the UART transmit scheduler, its byte sources and the shared transmitter.
// The master modport is the scheduler side; the slave modport is the sources/transmitter side.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_busy;
    logic               tx_write_en;
    logic [7:0]         tx_data;
    logic               tx_tick;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_write_en, tx_data, tx_tick
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_write_en, tx_data, tx_tick
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler and bit-rate sequencer for a shared 8-bit UART transmitter.
// Grants one byte source at a time, pulses the transmitter load, then paces bits off tx_busy.
module uart_tx_sched #(
    parameter int N_REQ         = 4,
    parameter int CLKS_PER_BIT  = 868,
    parameter int START_TIMEOUT = 4,
    localparam int GW = $clog2(N_REQ),
    localparam int BW = $clog2(CLKS_PER_BIT),
    localparam int TW = $clog2(START_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_sched_if.master   bus,
    output logic [GW-1:0]     grant_id,
    output logic              active,
    output logic              err_no_start
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [GW-1:0] last_grant_reg, last_grant_next;
    logic [GW-1:0] grant_id_reg, grant_id_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic          tick_reg, tick_next;
    logic          err_reg, err_next;

    logic [7:0]       req_byte [N_REQ];
    logic [N_REQ-1:0] ready_vec;
    logic [GW-1:0]    win_idx;
    logic             win_found;
    logic             grant_ok;

    // Scanning offsets from farthest to nearest leaves the nearest valid
    // index after last_grant as the winner; offset N_REQ is last_grant itself.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(unsigned'(last_grant_reg)) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req_valid[GW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    assign grant_ok = (state_reg == IDLE) && !bus.tx_busy && win_found && !reset;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_byte[gi]  = bus.req_data[8*gi +: 8];
        assign ready_vec[gi] = grant_ok && (win_idx == GW'(gi));
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        tx_data_next    = tx_data_reg;
        to_cnt_next     = to_cnt_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (grant_ok) begin
                    tx_data_next    = req_byte[win_idx];
                    grant_id_next   = win_idx;
                    last_grant_next = win_idx;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_next = '0;
                state_next  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (to_cnt_reg == TW'(START_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit pacing follows tx_busy alone so frames issued by other masters are paced too.
    always_comb begin
        bit_cnt_next = '0;
        tick_next    = 1'b0;
        if (bus.tx_busy) begin
            if (bit_cnt_reg == BW'(CLKS_PER_BIT - 1)) begin
                tick_next = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt_reg + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(N_REQ - 1);
            grant_id_reg   <= '0;
            tx_data_reg    <= '0;
            to_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            tick_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            tx_data_reg    <= tx_data_next;
            to_cnt_reg     <= to_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            tick_reg       <= tick_next;
            err_reg        <= err_next;
        end
    end

    assign bus.req_ready   = ready_vec;
    assign bus.tx_write_en = (state_reg == ISSUE);
    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_tick     = tick_reg;
    assign grant_id        = grant_id_reg;
    assign active          = (state_reg != IDLE);
    assign err_no_start    = err_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a stub transmitter that holds tx_busy for one frame.
// N_REQ=4, CLKS_PER_BIT=4, START_TIMEOUT=4.
module tb_uart_tx_sched;
    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int STO = 4;

    logic       clk;
    logic       reset;
    logic [1:0] grant_id;
    logic       active;
    logic       err_no_start;
    logic       stub_en;
    logic       force_busy;
    int         busy_cnt;
    int         n_wr;
    int         n_chk;
    int         n_err;

    uart_tx_sched_if #(.N_REQ(N)) bus ();

    uart_tx_sched #(
        .N_REQ(N),
        .CLKS_PER_BIT(CPB),
        .START_TIMEOUT(STO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant_id(grant_id),
        .active(active),
        .err_no_start(err_no_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub transmitter: busy rises the cycle after the load pulse, lasts 10*CPB+1 cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (bus.tx_write_en && stub_en) begin
            busy_cnt <= 10 * CPB + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.tx_busy = (busy_cnt != 0) || force_busy;

    initial n_wr = 0;
    always @(posedge clk) begin
        if (bus.tx_write_en) begin
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"},  32'(bus.req_ready),   32'h0);
        chk({pfx, "_wr"},     32'(bus.tx_write_en), 32'h0);
        chk({pfx, "_tick"},   32'(bus.tx_tick),     32'h0);
        chk({pfx, "_data"},   32'(bus.tx_data),     32'h0);
        chk({pfx, "_gid"},    32'(grant_id),        32'h0);
        chk({pfx, "_active"}, 32'(active),          32'h0);
        chk({pfx, "_err"},    32'(err_no_start),    32'h0);
    endtask

    // Waits for an accept, checks it goes to requester idx, and returns in the ISSUE cycle.
    task automatic do_grant(input string tag, input int idx, input logic [7:0] exp_byte,
                            output int waited);
        #1;
        waited = 0;
        while (bus.req_ready == '0 && waited < 200) begin
            cyc();
            waited++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << idx);
        cyc();
        chk({tag, "_ready_pulse"}, 32'(bus.req_ready),   32'h0);
        chk({tag, "_wr"},          32'(bus.tx_write_en), 32'h1);
        chk({tag, "_data"},        32'(bus.tx_data),     32'(exp_byte));
        chk({tag, "_gid"},         32'(grant_id),        32'(idx));
    endtask

    task automatic wait_idle(input string tag);
        int w;
        #1;
        w = 0;
        while (active && w < 200) begin
            cyc();
            w++;
        end
        chk({tag, "_idle"}, 32'(active), 32'h0);
    endtask

    // Called in the ISSUE cycle; k counts cycles after it, stopping once active falls.
    task automatic frame_watch(output int n_t, output int first_t, output int last_t,
                               output int bad_sp, output int fall);
        n_t = 0;
        first_t = -1;
        last_t = -1;
        bad_sp = 0;
        fall = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (bus.tx_tick) begin
                if (first_t < 0) first_t = k;
                else if (k - last_t != CPB) bad_sp++;
                last_t = k;
                n_t++;
            end
            if (!active) begin
                fall = k;
                break;
            end
        end
    endtask

    initial begin
        int w, nt, ft, lt, bs, fl, nready;
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        stub_en = 1'b1;
        force_busy = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h0000_0055;

        // Reset held with a request pending, then first grant and full frame.
        repeat (3) cyc();
        chk_reset_vals("rst1");
        reset = 1'b0;
        do_grant("t1", 0, 8'h55, w);
        chk("t1_wait", 32'(w), 32'd0);
        bus.req_valid = 4'b0000;
        chk("t1_active", 32'(active), 32'h1);
        frame_watch(nt, ft, lt, bs, fl);
        chk("t1_ticks", 32'(nt), 32'd10);
        chk("t1_first_tick", 32'(ft), 32'd5);
        chk("t1_last_tick", 32'(lt), 32'd41);
        chk("t1_tick_spacing", 32'(bs), 32'd0);
        chk("t1_active_fall", 32'(fl), 32'd43);
        chk("t1_data_hold", 32'(bus.tx_data), 32'h55);

        // All four valid: round-robin 0,1,2,3,0 at full throughput.
        reset = 1'b1;
        bus.req_data = 32'hA3A2_A1A0;
        bus.req_valid = 4'b1111;
        repeat (2) cyc();
        reset = 1'b0;
        do_grant("rr0", 0, 8'hA0, w);
        do_grant("rr1", 1, 8'hA1, w);
        chk("rr1_spacing", 32'(w), 32'd43);
        do_grant("rr2", 2, 8'hA2, w);
        do_grant("rr3", 3, 8'hA3, w);
        do_grant("rr4", 0, 8'hA0, w);
        chk("rr4_spacing", 32'(w), 32'd43);
        bus.req_valid = 4'b0000;
        wait_idle("rr");

        // Wrap-around search and skipping a requester that withdrew.
        bus.req_valid = 4'b1000;
        do_grant("w3", 3, 8'hA3, w);
        bus.req_valid = 4'b0000;
        wait_idle("w3");
        bus.req_valid = 4'b0100;
        do_grant("wrap2", 2, 8'hA2, w);
        bus.req_valid = 4'b0000;
        wait_idle("wrap2");
        bus.req_valid = 4'b0011;
        do_grant("s0", 0, 8'hA0, w);
        bus.req_valid = 4'b0110;
        repeat (10) cyc();
        bus.req_valid = 4'b0100;
        do_grant("skip1", 2, 8'hA2, w);
        bus.req_valid = 4'b0000;
        wait_idle("skip1");
        chk("write_count", 32'(n_wr), 32'd10);

        // Transmitter never starts: timeout, error flag, recovery.
        stub_en = 1'b0;
        bus.req_valid = 4'b0001;
        do_grant("to", 0, 8'hA0, w);
        bus.req_valid = 4'b0000;
        repeat (STO) cyc();
        chk("to_err_early", 32'(err_no_start), 32'h0);
        chk("to_active_early", 32'(active), 32'h1);
        cyc();
        chk("to_err_set", 32'(err_no_start), 32'h1);
        chk("to_back_idle", 32'(active), 32'h0);
        stub_en = 1'b1;
        bus.req_valid = 4'b0010;
        do_grant("after_to", 1, 8'hA1, w);
        chk("after_to_wait", 32'(w), 32'd0);
        bus.req_valid = 4'b0000;

        // Reset during the fifth tick of a frame.
        repeat (21) cyc();
        chk("tick5", 32'(bus.tx_tick), 32'h1);
        chk("err_sticky", 32'(err_no_start), 32'h1);
        reset = 1'b1;
        cyc();
        chk_reset_vals("rst_mid");
        reset = 1'b0;
        bus.req_valid = 4'b0100;
        do_grant("post_rst", 2, 8'hA2, w);
        bus.req_valid = 4'b0000;
        frame_watch(nt, ft, lt, bs, fl);
        chk("post_rst_ticks", 32'(nt), 32'd10);
        chk("post_rst_first_tick", 32'(ft), 32'd5);

        // Foreign frame in progress while idle with a request pending.
        force_busy = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        nready = 0;
        nt = 0;
        ft = -1;
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) cyc();
            if (bus.req_ready != '0) nready++;
            if (bus.tx_tick) begin
                nt++;
                if (ft < 0) ft = j;
            end
        end
        chk("fb_no_ready", 32'(nready), 32'd0);
        chk("fb_ticks", 32'(nt), 32'd3);
        chk("fb_first_tick", 32'(ft), 32'd4);
        cyc();
        force_busy = 1'b0;
        #1;
        chk("fb_grant_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        chk("fb_grant_wr", 32'(bus.tx_write_en), 32'h1);
        chk("fb_grant_gid", 32'(grant_id), 32'h0);
        bus.req_valid = 4'b0000;
        wait_idle("fb");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
